// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the syn_fifo burst drain path: FSM encodings and buffer sizing.
package fifo_burst_reader_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned OCC_WIDTH = 2;
    localparam int unsigned OCC_EXT_W = OCC_WIDTH + 1;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry in-order buffer that absorbs the FIFO read latency in front of the output stream.
module fifo_rd_skid_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [OCC_WIDTH-1:0]  occ_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [OCC_WIDTH-1:0]  occ_q, occ_d;
    logic                  pop_ok, push_ok;

    assign pop_ok  = pop_i && (occ_q != OCC_WIDTH'(0));
    assign push_ok = push_i && ((occ_q != OCC_WIDTH'(BUF_DEPTH)) || pop_ok);

    // Head always holds the oldest word; tail only used when both entries are full.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push_ok && pop_ok) begin
            if (occ_q == OCC_WIDTH'(BUF_DEPTH)) begin
                head_d = tail_q;
                tail_d = push_data_i;
            end else begin
                head_d = push_data_i;
            end
        end else if (push_ok) begin
            if (occ_q == OCC_WIDTH'(0)) begin
                head_d = push_data_i;
            end else begin
                tail_d = push_data_i;
            end
            occ_d = occ_q + OCC_WIDTH'(1);
        end else if (pop_ok) begin
            head_d = tail_q;
            occ_d  = occ_q - OCC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = head_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a commanded burst from syn_fifo and re-emits it on a valid/ready stream with a last flag.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1024,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_valid,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    logic [1:0]           state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] issued_q, issued_d;
    logic [LEN_WIDTH-1:0] sent_q, sent_d;
    logic                 inflight_q;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [OCC_WIDTH-1:0] occ;
    logic [OCC_EXT_W-1:0] occ_after;
    logic                 pop, push, rd_en_c;

    assign pop  = m_valid && m_ready;
    // A read-valid not backed by our own request is a stray and must not land in the buffer.
    assign push = fifo_valid && inflight_q;

    assign occ_after = OCC_EXT_W'(occ) + OCC_EXT_W'(inflight_q) - OCC_EXT_W'(pop);
    assign rd_en_c   = (state_q == ST_RUN) && !fifo_empty && (issued_q < len_q)
                       && (occ_after < OCC_EXT_W'(BUF_DEPTH));

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (fifo_rd_data),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (m_data)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        sent_d   = sent_q;
        if (rd_en_c) begin
            issued_d = issued_q + LEN_WIDTH'(1);
        end
        if (pop) begin
            sent_d = sent_q + LEN_WIDTH'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d    = burst_len;
                    issued_d = '0;
                    sent_d   = '0;
                    state_d  = (burst_len == LEN_WIDTH'(0)) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issued_q == len_q) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Leave as soon as the final handshake drains the buffer so done lands next cycle.
                if (!inflight_q && ((occ == OCC_WIDTH'(0)) || ((occ == OCC_WIDTH'(1)) && pop))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            inflight_q <= rd_en_c;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign fifo_rd_en = rd_en_c;
    assign m_valid    = (occ != OCC_WIDTH'(0));
    assign m_last     = m_valid && (sent_q == (len_q - LEN_WIDTH'(1)));

endmodule
